// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Request/response front end for a single-port memory. Host requests are
// buffered in a request FIFO and issued in order to the memory, at most one
// command per cycle. Read data comes back two cycles after issue. It is
// captured into a response FIFO together with the read address. Reads issue
// only while the response FIFO has credit for every read in flight, so a
// capture never finds the response FIFO full.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake (req_wr, req_addr, req_data)
//   rsp_valid/rsp_ready        response handshake (rsp_data, rsp_addr)
//   mem_wr_en/mem_address/     registered command to the memory
//   mem_data_in
//   mem_data_out/mem_valid_out read data returned by the memory
//   busy                       work queued, in flight or awaiting the host
//   protocol_err               sticky: memory failed to return expected data
module mem_access_ctrl #(
    parameter int D_WIDTH   = 32,
    parameter int A_WIDTH   = 4,
    parameter int REQ_DEPTH = 4,
    parameter int RSP_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_wr,
    input  logic [A_WIDTH-1:0] req_addr,
    input  logic [D_WIDTH-1:0] req_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [D_WIDTH-1:0] rsp_data,
    output logic [A_WIDTH-1:0] rsp_addr,
    output logic               mem_wr_en,
    output logic [A_WIDTH-1:0] mem_address,
    output logic [D_WIDTH-1:0] mem_data_in,
    input  logic [D_WIDTH-1:0] mem_data_out,
    input  logic               mem_valid_out,
    output logic               busy,
    output logic               protocol_err
);

    localparam int RQ_AW = $clog2(REQ_DEPTH);
    localparam int RQ_CW = RQ_AW + 1;
    localparam int RS_AW = $clog2(RSP_DEPTH);
    localparam int RS_CW = RS_AW + 1;
    localparam int CR_W  = RS_CW + 1;

    // Request FIFO
    logic [REQ_DEPTH-1:0] r_rq_wr;
    logic [A_WIDTH-1:0]   r_rq_addr [REQ_DEPTH];
    logic [D_WIDTH-1:0]   r_rq_data [REQ_DEPTH];
    logic [RQ_AW-1:0]     r_rq_wptr;
    logic [RQ_AW-1:0]     r_rq_rptr;
    logic [RQ_CW-1:0]     r_rq_cnt;

    // Response FIFO
    logic [A_WIDTH-1:0]   r_rs_addr [RSP_DEPTH];
    logic [D_WIDTH-1:0]   r_rs_data [RSP_DEPTH];
    logic [RS_AW-1:0]     r_rs_wptr;
    logic [RS_AW-1:0]     r_rs_rptr;
    logic [RS_CW-1:0]     r_rs_cnt;

    // Memory command and read-tracking pipeline
    logic                 r_live;
    logic                 r_mem_wr_en;
    logic [A_WIDTH-1:0]   r_mem_address;
    logic [D_WIDTH-1:0]   r_mem_data_in;
    logic                 r_rd_s1;
    logic                 r_rd_s2;
    logic [A_WIDTH-1:0]   r_a_s1;
    logic [A_WIDTH-1:0]   r_a_s2;
    logic                 r_proto_err;

    logic                 w_rq_full;
    logic                 w_rq_empty;
    logic                 w_rs_empty;
    logic                 w_req_ready;
    logic                 w_rsp_valid;
    logic                 w_push_req;
    logic                 w_pop_rsp;
    logic                 w_head_wr;
    logic [A_WIDTH-1:0]   w_head_addr;
    logic [D_WIDTH-1:0]   w_head_data;
    logic [CR_W-1:0]      w_inflight;
    logic                 w_credit_ok;
    logic                 w_issue;
    logic                 w_capture;

    // Handshakes, FIFO status and the issue/credit decision
    always_comb begin
        w_rq_full   = (r_rq_cnt == RQ_CW'(REQ_DEPTH));
        w_rq_empty  = (r_rq_cnt == {RQ_CW{1'b0}});
        w_rs_empty  = (r_rs_cnt == {RS_CW{1'b0}});
        // r_live keeps req_ready low until the first edge after reset release
        w_req_ready = r_live & ~w_rq_full;
        w_rsp_valid = ~w_rs_empty;
        w_push_req  = req_valid & w_req_ready;
        w_pop_rsp   = w_rsp_valid & rsp_ready;
        w_head_wr   = r_rq_wr[r_rq_rptr];
        w_head_addr = r_rq_addr[r_rq_rptr];
        w_head_data = r_rq_data[r_rq_rptr];
        // Buffered responses plus reads still travelling through the memory
        w_inflight  = CR_W'(r_rs_cnt) + CR_W'(r_rd_s1) + CR_W'(r_rd_s2);
        w_credit_ok = (w_inflight < CR_W'(RSP_DEPTH));
        w_capture   = r_rd_s2 & mem_valid_out;
        w_issue     = 1'b0;
        if (w_rq_empty) begin
            w_issue = 1'b0;
        end else if (w_head_wr) begin
            w_issue = 1'b1;
        end else begin
            w_issue = w_credit_ok;
        end
    end

    // Request FIFO storage (payload only, needs no reset)
    always_ff @(posedge clk) begin
        if (w_push_req) begin
            r_rq_wr[r_rq_wptr]   <= req_wr;
            r_rq_addr[r_rq_wptr] <= req_addr;
            r_rq_data[r_rq_wptr] <= req_data;
        end
    end

    // Request FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live    <= 1'b0;
            r_rq_wptr <= {RQ_AW{1'b0}};
            r_rq_rptr <= {RQ_AW{1'b0}};
            r_rq_cnt  <= {RQ_CW{1'b0}};
        end else begin
            r_live <= 1'b1;
            if (w_push_req) begin
                r_rq_wptr <= r_rq_wptr + RQ_AW'(1);
            end
            if (w_issue) begin
                r_rq_rptr <= r_rq_rptr + RQ_AW'(1);
            end
            case ({w_push_req, w_issue})
                2'b10:   r_rq_cnt <= r_rq_cnt + RQ_CW'(1);
                2'b01:   r_rq_cnt <= r_rq_cnt - RQ_CW'(1);
                default: r_rq_cnt <= r_rq_cnt;
            endcase
        end
    end

    // Memory command registers; an idle cycle is a harmless read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_wr_en   <= 1'b0;
            r_mem_address <= {A_WIDTH{1'b0}};
            r_mem_data_in <= {D_WIDTH{1'b0}};
            r_rd_s1       <= 1'b0;
            r_a_s1        <= {A_WIDTH{1'b0}};
        end else if (w_issue) begin
            r_mem_wr_en   <= w_head_wr;
            r_mem_address <= w_head_addr;
            r_mem_data_in <= w_head_wr ? w_head_data : {D_WIDTH{1'b0}};
            r_rd_s1       <= ~w_head_wr;
            if (!w_head_wr) begin
                r_a_s1 <= w_head_addr;
            end
        end else begin
            r_mem_wr_en   <= 1'b0;
            r_mem_data_in <= {D_WIDTH{1'b0}};
            r_rd_s1       <= 1'b0;
        end
    end

    // Second read-tracking stage and the sticky missing-data flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_s2     <= 1'b0;
            r_a_s2      <= {A_WIDTH{1'b0}};
            r_proto_err <= 1'b0;
        end else begin
            r_rd_s2 <= r_rd_s1;
            r_a_s2  <= r_a_s1;
            if (r_rd_s2 && !mem_valid_out) begin
                r_proto_err <= 1'b1;
            end
        end
    end

    // Response FIFO storage; cleared so rsp_data/rsp_addr read zero after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RSP_DEPTH; i++) begin
                r_rs_addr[i] <= {A_WIDTH{1'b0}};
                r_rs_data[i] <= {D_WIDTH{1'b0}};
            end
        end else if (w_capture) begin
            r_rs_addr[r_rs_wptr] <= r_a_s2;
            r_rs_data[r_rs_wptr] <= mem_data_out;
        end
    end

    // Response FIFO pointers and occupancy; credit keeps capture from overflowing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rs_wptr <= {RS_AW{1'b0}};
            r_rs_rptr <= {RS_AW{1'b0}};
            r_rs_cnt  <= {RS_CW{1'b0}};
        end else begin
            if (w_capture) begin
                r_rs_wptr <= r_rs_wptr + RS_AW'(1);
            end
            if (w_pop_rsp) begin
                r_rs_rptr <= r_rs_rptr + RS_AW'(1);
            end
            case ({w_capture, w_pop_rsp})
                2'b10:   r_rs_cnt <= r_rs_cnt + RS_CW'(1);
                2'b01:   r_rs_cnt <= r_rs_cnt - RS_CW'(1);
                default: r_rs_cnt <= r_rs_cnt;
            endcase
        end
    end

    assign req_ready    = w_req_ready;
    assign rsp_valid    = w_rsp_valid;
    assign rsp_data     = r_rs_data[r_rs_rptr];
    assign rsp_addr     = r_rs_addr[r_rs_rptr];
    assign mem_wr_en    = r_mem_wr_en;
    assign mem_address  = r_mem_address;
    assign mem_data_in  = r_mem_data_in;
    assign busy         = ~w_rq_empty | r_rd_s1 | r_rd_s2 | ~w_rs_empty;
    assign protocol_err = r_proto_err;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;
    localparam int DW = 32;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_wr = 1'b0;
    logic [AW-1:0] req_addr = 4'd0;
    logic [DW-1:0] req_data = 32'd0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [DW-1:0] rsp_data;
    logic [AW-1:0] rsp_addr;
    logic          mem_wr_en;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_data_in;
    logic [DW-1:0] mem_data_out;
    logic          mem_valid_out;
    logic          busy;
    logic          protocol_err;

    // Behavioural single-port memory: registered read, registered valid
    logic [DW-1:0] mem_arr [16];
    logic [DW-1:0] mem_dout;
    logic          mem_vld = 1'b0;
    logic          drop = 1'b0;

    // Reference contents as seen by the host at request-accept time
    logic [DW-1:0] model [16];

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } exp_t;
    exp_t sb_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int n_rsp   = 0;
    int snap;

    always #5 clk = ~clk;

    mem_access_ctrl #(.D_WIDTH(DW), .A_WIDTH(AW), .REQ_DEPTH(4), .RSP_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
        .req_addr(req_addr), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_addr(rsp_addr),
        .mem_wr_en(mem_wr_en), .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_data_out(mem_data_out), .mem_valid_out(mem_valid_out),
        .busy(busy), .protocol_err(protocol_err)
    );

    assign mem_data_out  = mem_dout;
    assign mem_valid_out = mem_vld & ~drop;

    always @(posedge clk) begin
        if (mem_wr_en) mem_arr[mem_address] <= mem_data_in;
        mem_dout <= mem_arr[mem_address];
        mem_vld  <= 1'b1;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard pop: a response is consumed at the next rising edge
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            exp_t e;
            n_rsp++;
            if (sb_q.size() == 0) begin
                check_eq("rsp_unexpected", 64'(sb_q.size()), 64'd1);
            end else begin
                e = sb_q.pop_front();
                check_eq("rsp_data", 64'(rsp_data), 64'(e.d));
                check_eq("rsp_addr", 64'(rsp_addr), 64'(e.a));
            end
        end
    end

    // Drive one request; returns #1 after the accepting edge
    task automatic send(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic exp_rsp);
        int t = 0;
        req_valid = 1'b1;
        req_wr    = wr;
        req_addr  = a;
        req_data  = d;
        while (!req_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (!req_ready) begin
            check_eq("req_ready_timeout", 64'(req_ready), 64'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        if (wr) model[a] = d;
        else if (exp_rsp) sb_q.push_back({a, model[a]});
        req_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int t = 0;
        while ((sb_q.size() != 0 || busy) && t < 300) begin
            @(posedge clk); #1;
            t++;
        end
        check_eq({tag, "_busy"}, 64'(busy), 64'd0);
        check_eq({tag, "_left"}, 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #2;
        check_eq("rst_req_ready", 64'(req_ready), 64'd0);
        check_eq("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("rst_rsp_data", 64'(rsp_data), 64'd0);
        check_eq("rst_rsp_addr", 64'(rsp_addr), 64'd0);
        check_eq("rst_mem_wr_en", 64'(mem_wr_en), 64'd0);
        check_eq("rst_mem_address", 64'(mem_address), 64'd0);
        check_eq("rst_mem_data_in", 64'(mem_data_in), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_protocol_err", 64'(protocol_err), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_hold_req_ready", 64'(req_ready), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("post_rst_req_ready", 64'(req_ready), 64'd1);

        // Idle with memory valid_out high: nothing may be captured
        repeat (10) @(posedge clk);
        #1;
        check_eq("idle_mem_valid", 64'(mem_valid_out), 64'd1);
        check_eq("idle_rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("idle_busy", 64'(busy), 64'd0);

        // Preload every location through the controller
        rsp_ready = 1'b1;
        for (int i = 0; i < 16; i++) send(1'b1, 4'(i), 32'hA500_0000 | 32'(i * 17), 1'b0);

        // Write then read address 3 with latency checks
        send(1'b1, 4'd3, 32'hDEAD_BEEF, 1'b0);
        @(posedge clk); #1;
        check_eq("wr_issue_en", 64'(mem_wr_en), 64'd1);
        check_eq("wr_issue_addr", 64'(mem_address), 64'd3);
        check_eq("wr_issue_data", 64'(mem_data_in), 64'hDEAD_BEEF);
        send(1'b0, 4'd3, 32'd0, 1'b1);
        @(posedge clk); #1;
        check_eq("rd_lat_e1", 64'(rsp_valid), 64'd0);
        @(posedge clk); #1;
        check_eq("rd_lat_e2", 64'(rsp_valid), 64'd0);
        @(posedge clk); #1;
        check_eq("rd_lat_e3", 64'(rsp_valid), 64'd1);
        check_eq("rd_lat_data", 64'(rsp_data), 64'hDEAD_BEEF);
        check_eq("rd_lat_addr", 64'(rsp_addr), 64'd3);
        drain("t1");

        // Back-to-back read-after-write on address 5
        send(1'b1, 4'd5, 32'h11, 1'b0);
        send(1'b0, 4'd5, 32'd0, 1'b1);
        send(1'b1, 4'd5, 32'h22, 1'b0);
        send(1'b0, 4'd5, 32'd0, 1'b1);
        drain("t2");

        // Backpressure: 8 reads with the host not accepting responses
        rsp_ready = 1'b0;
        snap = n_rsp;
        for (int i = 0; i < 8; i++) send(1'b0, 4'(i), 32'd0, 1'b1);
        repeat (6) @(posedge clk);
        #1;
        check_eq("bp_req_ready", 64'(req_ready), 64'd0);
        check_eq("bp_rsp_valid", 64'(rsp_valid), 64'd1);
        check_eq("bp_busy", 64'(busy), 64'd1);
        check_eq("bp_last_issued", 64'(mem_address), 64'd3);
        check_eq("bp_head_addr", 64'(rsp_addr), 64'd0);
        rsp_ready = 1'b1;
        drain("t3");
        check_eq("bp_rsp_count", 64'(n_rsp - snap), 64'd8);

        // Memory withholds valid_out on a read's capture cycle
        drop = 1'b1;
        send(1'b0, 4'd9, 32'd0, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        drop = 1'b0;
        check_eq("perr_set", 64'(protocol_err), 64'd1);
        check_eq("perr_no_rsp", 64'(rsp_valid), 64'd0);
        check_eq("perr_busy", 64'(busy), 64'd0);
        send(1'b0, 4'd10, 32'd0, 1'b1);
        drain("t5");
        check_eq("perr_sticky", 64'(protocol_err), 64'd1);

        // Reset with 2 responses buffered and 2 reads in flight
        rsp_ready = 1'b0;
        send(1'b0, 4'd1, 32'd0, 1'b1);
        send(1'b0, 4'd2, 32'd0, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        send(1'b0, 4'd4, 32'd0, 1'b1);
        send(1'b0, 4'd6, 32'd0, 1'b1);
        @(posedge clk); #1;
        check_eq("mid_busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        sb_q.delete();
        check_eq("mid_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("mid_rst_rsp_data", 64'(rsp_data), 64'd0);
        check_eq("mid_rst_req_ready", 64'(req_ready), 64'd0);
        check_eq("mid_rst_busy", 64'(busy), 64'd0);
        check_eq("mid_rst_mem_address", 64'(mem_address), 64'd0);
        check_eq("mid_rst_perr", 64'(protocol_err), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        snap = n_rsp;
        repeat (10) @(posedge clk);
        #1;
        check_eq("post_rst_no_rsp", 64'(n_rsp - snap), 64'd0);
        check_eq("post_rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check_eq("post_rst_busy", 64'(busy), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Request/response front end that sits directly upstream of the single-port memory and drives its wr_en/address/data_in inputs.
- Consumes the memory's data_out/valid_out and returns read data to the host.
- Decouples the host with a request FIFO and a credit-protected response FIFO, and preserves strict in-order execution.
- Host sees valid/ready handshakes on both the request and response sides.

Parameters:
D_WIDTH, 32, data width; must equal memory D_WIDTH
A_WIDTH, 4, address width; must equal memory A_WIDTH
REQ_DEPTH, 4, request FIFO entries; power of 2, >=2
RSP_DEPTH, 4, response FIFO entries; power of 2, >=2

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  host request valid
req_ready  out  1  request FIFO not full
req_wr  in  1  1=write, 0=read
req_addr  in  A_WIDTH  request address
req_data  in  D_WIDTH  write data; ignored for reads
rsp_valid  out  1  response FIFO not empty
rsp_ready  in  1  host accepts response
rsp_data  out  D_WIDTH  read data at response FIFO head
rsp_addr  out  A_WIDTH  address of the read at response FIFO head
mem_wr_en  out  1  to memory wr_en, registered
mem_address  out  A_WIDTH  to memory address, registered
mem_data_in  out  D_WIDTH  to memory data_in, registered
mem_data_out  in  D_WIDTH  from memory data_out
mem_valid_out  in  1  from memory valid_out
busy  out  1  any request queued, in flight, or response pending
protocol_err  out  1  sticky; expected read data missing

Behaviour:
- Reset (async, rst_n=0):
  - Both FIFOs empty.
  - req_ready=0 while rst_n=0, then 1 on the first clock edge after release.
  - rsp_valid=0, rsp_data=0, rsp_addr=0.
  - mem_wr_en=0, mem_address=0, mem_data_in=0.
  - rd_s1=rd_s2=0, busy=0, protocol_err=0.
  - Reset mid-operation discards all queued, in-flight and buffered transactions; nothing is replayed.
- Request side:
  - A push occurs on req_valid&&req_ready at the edge.
  - req_ready = !req_full, computed from registered count only; a same-cycle pop does not free a slot.
- Issue (one command per cycle max), pops the request FIFO head at the edge when head exists and either:
  - head is a write, or
  - head is a read and rsp_count + rd_s1 + rd_s2 < RSP_DEPTH (credit check).
- Effects of an issue:
  - On issue, mem_wr_en<=head.wr, mem_address<=head.addr, mem_data_in<=head.wr ? head.data : 0.
  - rd_s1<=!head.wr.
  - Otherwise mem_wr_en<=0, mem_data_in<=0, mem_address holds, rd_s1<=0. An idle cycle is a harmless memory read.
- Read tracking:
  - rd_s2<=rd_s1 each cycle.
  - Address pipe tracks alongside: a_s1 captures the issued read address, a_s2<=a_s1.
- Capture:
  - When rd_s2=1 and mem_valid_out=1, {a_s2, mem_data_out} is pushed into the response FIFO at that edge.
  - Memory valid_out on idle cycles is ignored (rd_s2=0).
  - rd_s2=1 with mem_valid_out=0 sets protocol_err (sticky until reset) and pushes nothing.
- Credit rule: the credit check guarantees the response FIFO is never full on capture. No overflow is possible; no data is dropped.
- Response side:
  - rsp_valid = !rsp_empty.
  - Pop on rsp_valid&&rsp_ready.
  - rsp_data/rsp_addr hold while rsp_valid && !rsp_ready.
  - Simultaneous capture and pop in the same cycle are both honoured; count is unchanged.
- Ordering:
  - Strictly in order; at most one memory command per cycle.
  - Read-after-write to the same address returns the new data (write issued edge N, read issued N+1, memory reads after write commits).
- Latency (empty FIFOs, rsp_ready=1):
  - Request accepted at edge 0 -> issued at edge 1 -> memory samples at edge 2 -> captured at edge 3.
  - rsp_valid high in the cycle after edge 3.
  - A write commits to memory at edge 2.
  - Throughput: 1 request/cycle sustained.
- busy = !req_empty | rd_s1 | rd_s2 | !rsp_empty.
- FIFO pointers wrap modulo depth; full/empty are derived from a count of width clog2(depth)+1.

Test Plan:
- Reset, then write addr 3 data 0xDEADBEEF, then read addr 3 -> mem_wr_en=1 with addr 3 one cycle after accept; rsp_valid 3 cycles after read accept with rsp_data=0xDEADBEEF, rsp_addr=3.
- Back-to-back write addr 5=0x11, read addr 5, write addr 5=0x22, read addr 5 on consecutive cycles -> responses 0x11 then 0x22, in order.
- rsp_ready=0, issue 8 reads (addrs 0..7) -> exactly 4 responses buffered and remaining reads stall in the request FIFO; req_ready=0 once 4 are queued. Release rsp_ready -> 8 responses in address order, no loss.
- Idle for 10 cycles after reset with mem_valid_out=1 from the memory -> rsp_valid stays 0 and busy=0.
- Force mem_valid_out=0 during a read's capture cycle -> protocol_err=1 and stays set; no response pushed.
- Assert rst_n=0 with 2 reads in flight and 2 responses buffered -> all outputs return to reset values immediately; no responses appear after reset release.
